// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer; MCTRL_PERF_CNT_EN adds retire/stall counters.
// Latency: R 4, lw 5, sw 4, beq 3, illegal 2 cycles, plus one cycle per memory-wait cycle.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with stable controls until MemReady.
module multicycle_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemToWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        Illegal,
    output logic [3:0]  State,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCount
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        WB_R    = 4'd3,
        ADDR    = 4'd4,
        MEM_RD  = 4'd5,
        WB_MEM  = 4'd6,
        MEM_WR  = 4'd7,
        EXEC_BR = 4'd8
    } stateT;

    typedef struct packed {
        logic       memReq;
        logic       memToWrite;
        logic       iorD;
        logic       irWrite;
        logic       pcWrite;
        logic       pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       illegal;
    } ctrlT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    stateT      stateQ;
    stateT      stateD;
    logic [5:0] opcodeQ;
    ctrlT       ctrl;
    ctrlT       ctrlOut;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= FETCH;
            opcodeQ <= '0;
        end else begin
            stateQ <= stateD;
            if (stateQ == DECODE) begin
                opcodeQ <= opcode;
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        ctrl   = '0;
        case (stateQ)
            FETCH: begin
                ctrl.memReq  = 1'b1;
                ctrl.aluSrcB = 2'b01;
                ctrl.irWrite = MemReady;
                ctrl.pcWrite = MemReady;
                if (MemReady) begin
                    stateD = DECODE;
                end
            end
            DECODE: begin
                // Branch target PC + (imm << 2) is formed here while the opcode is decoded.
                ctrl.aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:     stateD = EXEC_R;
                    OP_LW, OP_SW: stateD = ADDR;
                    OP_BEQ:       stateD = EXEC_BR;
                    default: begin
                        stateD       = FETCH;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = 2'b10;
                stateD       = WB_R;
            end
            WB_R: begin
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
                stateD        = FETCH;
            end
            ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = 2'b10;
                if (opcodeQ == OP_LW) begin
                    stateD = MEM_RD;
                end else if (opcodeQ == OP_SW) begin
                    stateD = MEM_WR;
                end else begin
                    stateD = FETCH;
                end
            end
            MEM_RD: begin
                ctrl.memReq = 1'b1;
                ctrl.iorD   = 1'b1;
                if (MemReady) begin
                    stateD = WB_MEM;
                end
            end
            WB_MEM: begin
                ctrl.memToReg = 1'b1;
                ctrl.regWrite = 1'b1;
                stateD        = FETCH;
            end
            MEM_WR: begin
                ctrl.memReq     = 1'b1;
                ctrl.iorD       = 1'b1;
                ctrl.memToWrite = 1'b1;
                if (MemReady) begin
                    stateD = FETCH;
                end
            end
            EXEC_BR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = 2'b01;
                ctrl.pcSrc   = 1'b1;
                ctrl.pcWrite = Zero;
                stateD       = FETCH;
            end
            default: begin
                stateD = FETCH;
            end
        endcase
    end

    // Reset silences every output combinationally, including Mealy terms.
    assign ctrlOut    = rst ? '0 : ctrl;
    assign MemReq     = ctrlOut.memReq;
    assign MemToWrite = ctrlOut.memToWrite;
    assign IorD       = ctrlOut.iorD;
    assign IRWrite    = ctrlOut.irWrite;
    assign PCWrite    = ctrlOut.pcWrite;
    assign PCSrc      = ctrlOut.pcSrc;
    assign ALUSrcA    = ctrlOut.aluSrcA;
    assign ALUSrcB    = ctrlOut.aluSrcB;
    assign ALUOp      = ctrlOut.aluOp;
    assign RegDst     = ctrlOut.regDst;
    assign MemToReg   = ctrlOut.memToReg;
    assign RegWrite   = ctrlOut.regWrite;
    assign Illegal    = ctrlOut.illegal;
    assign State      = rst ? 4'd0 : stateQ;

`ifdef MCTRL_PERF_CNT_EN
    logic [31:0] instrCountQ;
    logic [31:0] stallCountQ;
    logic        retire;

    assign retire = (stateD == FETCH) &&
                    ((stateQ == WB_R) || (stateQ == WB_MEM) ||
                     (stateQ == MEM_WR) || (stateQ == EXEC_BR));

    always_ff @(posedge clk) begin
        if (rst) begin
            instrCountQ <= '0;
            stallCountQ <= '0;
        end else begin
            if (retire) begin
                instrCountQ <= instrCountQ + 32'd1;
            end
            if (ctrl.memReq && !MemReady) begin
                stallCountQ <= stallCountQ + 32'd1;
            end
        end
    end

    assign InstrCount = rst ? '0 : instrCountQ;
    assign StallCount = rst ? '0 : stallCountQ;
`else
    assign InstrCount = '0;
    assign StallCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected state traces built from the
// instruction class and chosen wait counts, with directed cases followed by random ones.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        Zero;
    logic        MemReady;
    logic        MemReq, MemToWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp;
    logic        RegDst, MemToReg, RegWrite, Illegal;
    logic [3:0]  State;
    logic [31:0] InstrCount, StallCount;
    logic [14:0] outVec;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .MemReq(MemReq), .MemToWrite(MemToWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .Illegal(Illegal), .State(State), .InstrCount(InstrCount), .StallCount(StallCount)
    );

    assign outVec = {MemReq, MemToWrite, IorD, IRWrite, PCWrite, PCSrc, ALUSrcA,
                     ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, Illegal};

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } cycT;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ILL = 4;

    int          total = 0;
    int          bad   = 0;
    int unsigned expInstr = 0;
    int unsigned expStall = 0;

    function automatic logic [31:0] expCnt(input int unsigned v);
`ifdef MCTRL_PERF_CNT_EN
        return v;
`else
        return (v == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Control table: {MemReq,MemToWrite,IorD,IRWrite,PCWrite,PCSrc,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemToReg,RegWrite,Illegal}
    function automatic logic [14:0] expVec(input logic [3:0] st, input logic rdy,
                                           input logic z, input logic ill);
        case (st)
            4'd0: return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b0, 2'b01, 2'b00, 4'b0000};
            4'd1: return {7'b0, 2'b11, 2'b00, 3'b000, ill};
            4'd2: return {6'b0, 1'b1, 2'b00, 2'b10, 4'b0000};
            4'd3: return {7'b0, 2'b00, 2'b00, 4'b1010};
            4'd4: return {6'b0, 1'b1, 2'b10, 2'b00, 4'b0000};
            4'd5: return {3'b101, 4'b0, 2'b00, 2'b00, 4'b0000};
            4'd6: return {7'b0, 2'b00, 2'b00, 4'b0110};
            4'd7: return {3'b111, 4'b0, 2'b00, 2'b00, 4'b0000};
            4'd8: return {4'b0000, z, 1'b1, 1'b1, 2'b00, 2'b01, 4'b0000};
            default: return 15'h7fff;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, "_ctrl"}, {17'd0, outVec}, 32'd0);
        check({tag, "_state"}, {28'd0, State}, 32'd0);
        check({tag, "_icnt"}, InstrCount, 32'd0);
        check({tag, "_scnt"}, StallCount, 32'd0);
    endtask

    // zsel: 0/1 force Zero, 2 random. abortAt: trace index where rst is raised, -1 for none.
    task automatic runInstr(input int kind, input logic [5:0] opc, input int fw,
                            input int mw, input int zsel, input int abortAt);
        cycT  tr[$];
        logic z;
        for (int i = 0; i < fw; i++) tr.push_back('{4'd0, 1'b0});
        tr.push_back('{4'd0, 1'b1});
        tr.push_back('{4'd1, 1'($urandom_range(0, 1))});
        case (kind)
            K_R: begin
                tr.push_back('{4'd2, 1'($urandom_range(0, 1))});
                tr.push_back('{4'd3, 1'($urandom_range(0, 1))});
            end
            K_LW: begin
                tr.push_back('{4'd4, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) tr.push_back('{4'd5, 1'b0});
                tr.push_back('{4'd5, 1'b1});
                tr.push_back('{4'd6, 1'($urandom_range(0, 1))});
            end
            K_SW: begin
                tr.push_back('{4'd4, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) tr.push_back('{4'd7, 1'b0});
                tr.push_back('{4'd7, 1'b1});
            end
            K_BEQ: tr.push_back('{4'd8, 1'($urandom_range(0, 1))});
            default: ;
        endcase
        for (int i = 0; i < tr.size(); i++) begin
            if (i == abortAt) begin
                rst      = 1'b1;
                MemReady = 1'($urandom_range(0, 1));
                Zero     = 1'($urandom_range(0, 1));
                opcode   = opc;
                #1;
                checkQuiet("rst_mid");
                @(negedge clk);
                rst      = 1'b0;
                expInstr = 0;
                expStall = 0;
                return;
            end
            rst      = 1'b0;
            MemReady = tr[i].rdy;
            z        = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel == 1);
            Zero     = z;
            opcode   = (tr[i].st == 4'd1) ? opc : 6'($urandom_range(0, 63));
            #1;
            check("state", {28'd0, State}, {28'd0, tr[i].st});
            check("ctrl", {17'd0, outVec}, {17'd0, expVec(tr[i].st, tr[i].rdy, z, kind == K_ILL)});
            check("icnt", InstrCount, expCnt(expInstr));
            check("scnt", StallCount, expCnt(expStall));
            if ((tr[i].st == 4'd0 || tr[i].st == 4'd5 || tr[i].st == 4'd7) && !tr[i].rdy)
                expStall++;
            @(negedge clk);
        end
        if (kind != K_ILL) expInstr++;
    endtask

    function automatic logic [5:0] opFor(input int kind);
        logic [5:0] o;
        case (kind)
            K_R:   return 6'b000000;
            K_LW:  return 6'b100011;
            K_SW:  return 6'b101011;
            K_BEQ: return 6'b000100;
            default: begin
                do o = 6'($urandom_range(0, 63));
                while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 || o == 6'b000100);
                return o;
            end
        endcase
    endfunction

    initial begin
        int k, fw;
        rst      = 1'b1;
        opcode   = 6'd0;
        Zero     = 1'b0;
        MemReady = 1'b1;
        @(negedge clk);
        #1 checkQuiet("reset0");
        @(negedge clk);
        #1 checkQuiet("reset1");
        @(negedge clk);

        runInstr(K_R,   opFor(K_R),   0, 0, 2, -1);
        runInstr(K_LW,  opFor(K_LW),  0, 2, 2, -1);
        runInstr(K_SW,  opFor(K_SW),  0, 0, 2, -1);
        runInstr(K_BEQ, opFor(K_BEQ), 0, 0, 1, -1);
        runInstr(K_BEQ, opFor(K_BEQ), 0, 0, 0, -1);
        runInstr(K_ILL, 6'b111111,    0, 0, 2, -1);
        runInstr(K_SW,  opFor(K_SW),  2, 3, 2, -1);
        runInstr(K_LW,  opFor(K_LW),  0, 2, 2, 3);
        runInstr(K_R,   opFor(K_R),   1, 0, 2, -1);

        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 4);
            fw = $urandom_range(0, 3);
            runInstr(k, opFor(k), fw, $urandom_range(0, 3), 2,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, fw + 1) : -1);
        end

        MemReady = 1'b0;
        #1;
        check("end_state", {28'd0, State}, 32'd0);
        check("end_icnt", InstrCount, expCnt(expInstr));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
